// File: rtl/bsg_chip_pkg.sv
// Shared definitions for the early-terminating iterative integer divider.
package bsg_chip_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    NORM = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } idiv_state_e;

  // Iteration counter must hold every value 0..width inclusive.
  function automatic int idiv_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bsg_idiv_early_term_chk.sv
// Protocol checks for the divider handshake.
module bsg_idiv_early_term_chk (
  input logic clk_i,
  input logic reset_i,
  input logic v_o,
  input logic ready_o,
  input logic yumi_i
);

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

  a_ready_valid_exclusive: assert property (@(posedge clk_i) disable iff (reset_i) !(ready_o && v_o));

endmodule

// File: rtl/bsg_idiv_lzc.sv
// Leading-zero count of an unsigned word; an all-zero word counts as width_p.
module bsg_idiv_lzc
  import bsg_chip_pkg::*;
#(
  parameter int width_p = 64
) (
  input  logic [width_p-1:0]                        data,
  output logic [idiv_cnt_width(width_p)-1:0]        count
);

  localparam int cw_lp = idiv_cnt_width(width_p);

  // Scan upward so the highest set bit has the final say.
  always_comb begin
    count = cw_lp'(width_p);
    for (int i = 0; i < width_p; i++) begin
      if (data[i]) begin
        count = cw_lp'(width_p - 1 - i);
      end else begin
        count = count;
      end
    end
  end

endmodule

// File: rtl/bsg_idiv_early_term.sv
// Iterative radix-2 restoring divider that skips the dividend's leading zeros,
// taking width_p - lz DIV cycles per request.
module bsg_idiv_early_term
  import bsg_chip_pkg::*;
#(
  parameter int width_p     = 64,
  parameter int tag_width_p = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   v_i,
  output logic                   ready_o,
  input  logic [width_p-1:0]     dividend_i,
  input  logic [width_p-1:0]     divisor_i,
  input  logic                   signed_div_i,
  input  logic [tag_width_p-1:0] tag_i,
  output logic                   v_o,
  output logic [width_p-1:0]     quotient_o,
  output logic [width_p-1:0]     remainder_o,
  output logic [tag_width_p-1:0] tag_o,
  output logic                   div_zero_o,
  input  logic                   yumi_i
);

  localparam int cw_lp = idiv_cnt_width(width_p);

  idiv_state_e state, state_n;

  logic [width_p-1:0]     op_a, op_b;
  logic                   op_signed;
  logic [tag_width_p-1:0] op_tag;

  logic [width_p-1:0] shreg, acc, dabs;
  logic [cw_lp-1:0]   cnt;
  logic               neg_q, neg_r, dz;

  logic [width_p-1:0]     quot, rem;
  logic [tag_width_p-1:0] tag_q;
  logic                   div_zero;

  logic               accept, a_neg, b_neg;
  logic [width_p-1:0] a_abs, b_abs;
  logic [cw_lp-1:0]   lz, n;
  logic [width_p:0]   shifted, diff;
  logic               borrow;

  assign accept = v_i & (state == IDLE);
  assign a_neg  = op_signed & op_a[width_p-1];
  assign b_neg  = op_signed & op_b[width_p-1];
  assign a_abs  = a_neg ? -op_a : op_a;
  assign b_abs  = b_neg ? -op_b : op_b;
  assign n      = cw_lp'(width_p) - lz;

  bsg_idiv_lzc #(.width_p(width_p)) lzc (
    .data  (a_abs),
    .count (lz)
  );

  // The single shared subtractor: partial remainder with next dividend bit minus divisor.
  assign shifted = {acc, shreg[width_p-1]};
  assign diff    = shifted - {1'b0, dabs};
  assign borrow  = diff[width_p];

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = NORM; else state_n = IDLE;
      NORM:    if ((op_b == '0) || (n == '0)) state_n = FIX; else state_n = DIV;
      DIV:     if (cnt == cw_lp'(1)) state_n = FIX; else state_n = DIV;
      FIX:     state_n = DONE;
      DONE:    if (yumi_i) state_n = IDLE; else state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      op_a      <= '0;
      op_b      <= '0;
      op_signed <= 1'b0;
      op_tag    <= '0;
      shreg     <= '0;
      acc       <= '0;
      dabs      <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dz        <= 1'b0;
      quot      <= '0;
      rem       <= '0;
      tag_q     <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a      <= dividend_i;
            op_b      <= divisor_i;
            op_signed <= signed_div_i;
            op_tag    <= tag_i;
          end
        end
        NORM: begin
          shreg <= a_abs << lz;
          acc   <= '0;
          dabs  <= b_abs;
          cnt   <= n;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          dz    <= (op_b == '0);
        end
        DIV: begin
          // Quotient bits enter at the bottom as dividend bits leave the top.
          acc   <= borrow ? shifted[width_p-1:0] : diff[width_p-1:0];
          shreg <= {shreg[width_p-2:0], ~borrow};
          cnt   <= cnt - cw_lp'(1);
        end
        FIX: begin
          tag_q <= op_tag;
          if (dz) begin
            quot     <= '1;
            rem      <= op_a;
            div_zero <= 1'b1;
          end else begin
            quot     <= neg_q ? -shreg : shreg;
            rem      <= neg_r ? -acc : acc;
            div_zero <= 1'b0;
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign ready_o     = (state == IDLE);
  assign v_o         = (state == DONE);
  assign quotient_o  = quot;
  assign remainder_o = rem;
  assign tag_o       = tag_q;
  assign div_zero_o  = div_zero;

  bsg_idiv_early_term_chk chk (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_o     (v_o),
    .ready_o (ready_o),
    .yumi_i  (yumi_i)
  );

endmodule

// File: tb/tb_bsg_idiv_early_term.sv
// Randomized and directed bench for bsg_idiv_early_term against an arithmetic reference model.
module tb_bsg_idiv_early_term;

  localparam int W  = 16;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          reset_i, v_i, signed_div_i, yumi_i;
  logic [W-1:0]  dividend_i, divisor_i;
  logic [TW-1:0] tag_i;
  logic          ready_o, v_o, div_zero_o;
  logic [W-1:0]  quotient_o, remainder_o;
  logic [TW-1:0] tag_o;

  int errors = 0;
  int checks = 0;

  bsg_idiv_early_term #(.width_p(W), .tag_width_p(TW)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .v_i          (v_i),
    .ready_o      (ready_o),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .signed_div_i (signed_div_i),
    .tag_i        (tag_i),
    .v_o          (v_o),
    .quotient_o   (quotient_o),
    .remainder_o  (remainder_o),
    .tag_o        (tag_o),
    .div_zero_o   (div_zero_o),
    .yumi_i       (yumi_i)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero; latency from bit length of |a|.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic dz, output int lat);
    int sa, sb, ua, n;
    if (b == '0) begin
      q = '1; r = a; dz = 1'b1; lat = 2;
    end else begin
      dz = 1'b0;
      if (sgn) begin
        sa = $signed(a);
        sb = $signed(b);
      end else begin
        sa = int'(a);
        sb = int'(b);
      end
      q  = W'(sa / sb);
      r  = W'(sa % sb);
      ua = (sa < 0) ? -sa : sa;
      n  = 0;
      while ((ua >> n) != 0) n++;
      lat = n + 2;
    end
  endtask

  task automatic run_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         input logic [TW-1:0] tag, input int hold, input bit noise);
    logic [W-1:0] eq, er;
    logic         edz;
    int           elat, e;
    model(a, b, sgn, eq, er, edz, elat);
    @(negedge clk);
    check_val("ready_idle", ready_o, 1);
    v_i = 1'b1; dividend_i = a; divisor_i = b; signed_div_i = sgn; tag_i = tag;
    @(posedge clk);
    @(negedge clk);
    v_i = 1'b0;
    e = 0;
    while (!v_o && e < 4 * W) begin
      if (noise) begin
        v_i = 1'($urandom_range(0, 1));
        dividend_i = W'($urandom); divisor_i = W'($urandom);
        signed_div_i = 1'($urandom); tag_i = TW'($urandom);
      end
      @(posedge clk);
      e++;
      @(negedge clk);
    end
    v_i = 1'b0;
    check_val("latency", e, elat);
    check_val("quotient", quotient_o, eq);
    check_val("remainder", remainder_o, er);
    check_val("tag", tag_o, tag);
    check_val("div_zero", div_zero_o, edz);
    check_val("ready_in_done", ready_o, 0);
    for (int i = 0; i < hold; i++) begin
      v_i = i[0];
      dividend_i = W'($urandom); divisor_i = W'($urandom); tag_i = TW'($urandom);
      @(posedge clk);
      @(negedge clk);
      check_val("hold_v", v_o, 1);
      check_val("hold_q", quotient_o, eq);
      check_val("hold_r", remainder_o, er);
      check_val("hold_tag", tag_o, tag);
      check_val("hold_dz", div_zero_o, edz);
    end
    v_i = 1'b0;
    yumi_i = 1'b1;
    #1;
    check_val("no_reuse", ready_o, 0);
    @(posedge clk);
    @(negedge clk);
    yumi_i = 1'b0;
    check_val("ready_after_yumi", ready_o, 1);
    check_val("v_after_yumi", v_o, 0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return W'($urandom_range(0, 9));
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; signed_div_i = 1'b0;
    dividend_i = '0; divisor_i = '0; tag_i = '0;
    repeat (2) @(negedge clk);
    check_val("rst_ready", ready_o, 1);
    check_val("rst_v", v_o, 0);
    check_val("rst_q", quotient_o, 0);
    check_val("rst_r", remainder_o, 0);
    check_val("rst_tag", tag_o, 0);
    check_val("rst_dz", div_zero_o, 0);
    reset_i = 1'b0;

    run_req(16'd100, 16'd7, 1'b0, 4'd3, 0, 1'b0);
    run_req(16'hFFF9, 16'd2, 1'b1, 4'd1, 0, 1'b0);
    run_req(16'h0007, 16'hFFFE, 1'b1, 4'd2, 0, 1'b0);
    run_req(16'd5, 16'd0, 1'b0, 4'd4, 0, 1'b0);
    run_req(16'hFFFB, 16'd0, 1'b1, 4'd5, 0, 1'b0);
    run_req(16'h8000, 16'hFFFF, 1'b1, 4'd6, 0, 1'b0);
    run_req(16'hFFFF, 16'd1, 1'b0, 4'd7, 10, 1'b1);
    run_req(16'd0, 16'd5, 1'b1, 4'd8, 0, 1'b0);

    for (int k = 0; k < 150; k++) begin
      run_req(pick(), pick(), 1'($urandom), TW'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    end

    // Reset in the middle of a long division, then confirm recovery.
    run_req(16'd9, 16'd4, 1'b0, 4'd9, 0, 1'b0);
    @(negedge clk);
    v_i = 1'b1; dividend_i = 16'hFFFF; divisor_i = 16'd3; signed_div_i = 1'b0; tag_i = 4'd5;
    @(posedge clk);
    @(negedge clk);
    v_i = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    check_val("midrst_ready", ready_o, 1);
    check_val("midrst_v", v_o, 0);
    check_val("midrst_q", quotient_o, 0);
    check_val("midrst_r", remainder_o, 0);
    check_val("midrst_tag", tag_o, 0);
    @(negedge clk);
    reset_i = 1'b0;
    run_req(16'd100, 16'd7, 1'b0, 4'd3, 0, 1'b0);
    run_req(16'hFFFF, 16'd3, 1'b0, 4'd10, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bsg_idiv_early_term.md
BSG_IDIV_EARLY_TERM -- requirements
Module: bsg_idiv_early_term

Interface
REQ-001 SHALL have parameter width_p, default 64: operand and result width, at least 8.
REQ-002 SHALL have parameter tag_width_p, default 4: width of the request tag carried through with each request.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port v_i, input, 1 bit: a request is present.
REQ-006 SHALL have port ready_o, output, 1 bit: the block is idle and accepts a request.
REQ-007 SHALL have ports dividend_i and divisor_i, input, width_p bits each: the operands.
REQ-008 SHALL have port signed_div_i, input, 1 bit: 1 means two's-complement operands, 0 means unsigned.
REQ-009 SHALL have port tag_i, input, tag_width_p bits: request tag.
REQ-010 SHALL have port v_o, output, 1 bit: the result is valid.
REQ-011 SHALL have ports quotient_o and remainder_o, output, width_p bits each, and tag_o, output, tag_width_p bits: the result.
REQ-012 SHALL have port div_zero_o, output, 1 bit: the result came from a zero divisor.
REQ-013 SHALL have port yumi_i, input, 1 bit: the consumer takes the result.

Function
REQ-014 SHALL use states IDLE, NORM, DIV, FIX and DONE; ready_o=1 only in IDLE; v_o=1 only in DONE.
REQ-015 SHALL accept a request on an edge where v_i and ready_o are both 1, registering operands, sign mode and tag, then entering NORM.
REQ-016 NORM SHALL form |dividend| and |divisor| (for unsigned requests, the raw values) and the leading-zero count lz of |dividend|.
REQ-017 NORM SHALL set the iteration count n = width_p - lz and pre-shift |dividend| left by lz.
REQ-018 NORM SHALL go to FIX when the divisor is 0 or n = 0, and to DIV otherwise.
REQ-019 DIV SHALL perform one radix-2 restoring step per cycle for exactly n cycles, then go to FIX.
REQ-020 FIX SHALL negate the quotient when the operand signs differ (signed requests only) and give the remainder the dividend's sign, then go to DONE.
REQ-021 Latency: counting the accepting edge as edge 0, v_o SHALL rise after edge n+2, with n in 0..width_p.
REQ-022 Divide by zero SHALL give quotient all-ones, remainder = dividend_i unchanged and div_zero_o=1, with v_o after edge 2.
REQ-023 Dividend 0 with a non-zero divisor SHALL give quotient 0 and remainder 0, with v_o after edge 2.
REQ-024 Signed overflow (most-negative value / -1) SHALL give quotient = most-negative value and remainder 0.
REQ-025 In DONE, quotient_o, remainder_o, tag_o and div_zero_o SHALL hold stable until yumi_i=1; the next edge then returns to IDLE.
REQ-026 There SHALL be no same-cycle reuse: ready_o=0 in DONE, even while yumi_i=1.
REQ-027 yumi_i while v_o=0 SHALL be ignored, and an assertion SHALL flag it.
REQ-028 v_i while ready_o=0 SHALL be ignored, and the operand registers SHALL not change.

Reset
REQ-029 reset_i=1 SHALL immediately force IDLE, ready_o=1, v_o=0, div_zero_o=0, and zero the result and tag registers, in any state including DIV mid-iteration.
REQ-030 After reset deasserts, the first request SHALL be accepted on the first edge with v_i=1.

Structure
REQ-031 The state enum and the iteration-counter width ($clog2(width_p+1)) SHALL be defined in bsg_chip_pkg.
REQ-032 The leading-zero count SHALL be a separate sub-module bsg_idiv_lzc #(width_p), purely combinational.
REQ-033 The datapath SHALL be one width_p+1-bit subtractor, shared across all DIV cycles.

Verification
REQ-034 Unsigned 100 / 7, tag 3: n=7; v_o after edge 9 with q=14, r=2, tag_o=3.
REQ-035 Signed -7 / 2: q=-3 (all-ones except LSB 1, i.e. 0xFF..FD), r=-1; signed 7 / -2: q=-3, r=1.
REQ-036 Divide by zero, 5 / 0: v_o after edge 2 with q=all-ones, r=5, div_zero_o=1.
REQ-037 Signed overflow and full length: 0x8000..0 / -1 gives q=0x8000..0, r=0; unsigned all-ones / 1 gives n=width_p, v_o after edge width_p+2.
REQ-038 Backpressure: hold yumi_i=0 for 10 cycles in DONE; outputs stay stable and v_i pulses are ignored.
REQ-039 Reset mid-operation: assert reset_i at DIV cycle 5; ready_o=1 and v_o=0 at once; the next request completes correctly.
